// File: rtl/ras_ckpt_if.sv
// ras_ckpt_if: request/response bundle of the checkpointed return-address stack
//   master drives flush/push/pop/data and save/restore requests,
//   slave returns top_o, top_valid_o, count_o, overflow_o, underflow_o.
interface ras_ckpt_if #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter int NR_CKPT = 2
);
    logic                       flush_i;
    logic                       push_i;
    logic                       pop_i;
    logic [XLEN-1:0]            data_i;
    logic                       ckpt_save_i;
    logic [$clog2(NR_CKPT)-1:0] ckpt_save_id_i;
    logic                       ckpt_restore_i;
    logic [$clog2(NR_CKPT)-1:0] ckpt_restore_id_i;
    logic [XLEN-1:0]            top_o;
    logic                       top_valid_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic                       overflow_o;
    logic                       underflow_o;

    modport master (
        output flush_i, push_i, pop_i, data_i,
        output ckpt_save_i, ckpt_save_id_i, ckpt_restore_i, ckpt_restore_id_i,
        input  top_o, top_valid_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, push_i, pop_i, data_i,
        input  ckpt_save_i, ckpt_save_id_i, ckpt_restore_i, ckpt_restore_id_i,
        output top_o, top_valid_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/ras_ckpt.sv
// ras_ckpt: circular return-address stack with checkpoint save/restore
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : flush/push/pop/data requests, save/restore slot requests,
//                  top_o/top_valid_o/count_o from registers, overflow_o/underflow_o pulses
module ras_ckpt #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter int NR_CKPT = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ras_ckpt_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]   r_tos;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_mem    [DEPTH];
    logic [AW-1:0]   r_ck_tos [NR_CKPT];
    logic [CW-1:0]   r_ck_cnt [NR_CKPT];
    logic [XLEN-1:0] r_ck_top [NR_CKPT];
    logic            r_ovf;
    logic            r_udf;

    logic [AW-1:0]   w_tos_n;
    logic [CW-1:0]   w_cnt_n;
    logic            w_we;
    logic [AW-1:0]   w_wa;
    logic [XLEN-1:0] w_wd;
    logic            w_ovf_n;
    logic            w_udf_n;
    logic [XLEN-1:0] w_top_n;
    logic            w_rs_ok;
    logic            w_sv_ok;

    // ids beyond NR_CKPT only exist when NR_CKPT is not a power of two
    assign w_rs_ok = bus.ckpt_restore_i && (32'(bus.ckpt_restore_id_i) < NR_CKPT);
    assign w_sv_ok = bus.ckpt_save_i && (32'(bus.ckpt_save_id_i) < NR_CKPT);

    always_comb begin
        w_tos_n = r_tos;
        w_cnt_n = r_cnt;
        w_we    = 1'b0;
        w_wa    = r_tos;
        w_wd    = bus.data_i;
        w_ovf_n = 1'b0;
        w_udf_n = 1'b0;
        if (bus.flush_i) begin
            w_tos_n = '0;
            w_cnt_n = '0;
        end else if (w_rs_ok) begin
            // rewriting the saved top undoes a speculative push that clobbered it
            w_tos_n = r_ck_tos[bus.ckpt_restore_id_i];
            w_cnt_n = r_ck_cnt[bus.ckpt_restore_id_i];
            w_we    = 1'b1;
            w_wa    = r_ck_tos[bus.ckpt_restore_id_i];
            w_wd    = r_ck_top[bus.ckpt_restore_id_i];
        end else if (bus.push_i && bus.pop_i) begin
            w_we    = 1'b1;
            w_cnt_n = (r_cnt == '0) ? CW'(1) : r_cnt;
        end else if (bus.push_i) begin
            w_tos_n = r_tos + AW'(1);
            w_we    = 1'b1;
            w_wa    = r_tos + AW'(1);
            w_cnt_n = (r_cnt == FULL) ? r_cnt : r_cnt + CW'(1);
            w_ovf_n = (r_cnt == FULL);
        end else if (bus.pop_i) begin
            w_tos_n = (r_cnt != '0) ? r_tos - AW'(1) : r_tos;
            w_cnt_n = (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
            w_udf_n = (r_cnt == '0);
        end
    end

    // a save sees this cycle's write, forwarded when it lands on the new top
    assign w_top_n = (w_we && w_wa == w_tos_n) ? w_wd : r_mem[w_tos_n];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tos <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            for (int i = 0; i < NR_CKPT; i++) begin
                r_ck_tos[i] <= '0;
                r_ck_cnt[i] <= '0;
                r_ck_top[i] <= '0;
            end
        end else begin
            r_tos <= w_tos_n;
            r_cnt <= w_cnt_n;
            r_ovf <= w_ovf_n;
            r_udf <= w_udf_n;
            if (w_we) r_mem[w_wa] <= w_wd;
            if (w_sv_ok) begin
                r_ck_tos[bus.ckpt_save_id_i] <= w_tos_n;
                r_ck_cnt[bus.ckpt_save_id_i] <= w_cnt_n;
                r_ck_top[bus.ckpt_save_id_i] <= w_top_n;
            end
        end
    end

    assign bus.top_o       = r_mem[r_tos];
    assign bus.top_valid_o = (r_cnt != '0);
    assign bus.count_o     = r_cnt;
    assign bus.overflow_o  = r_ovf;
    assign bus.underflow_o = r_udf;
endmodule
